// File: rtl/tx_timer_multi.sv
// tx_timer_multi
// Programmable timeout generator for the C-PHY master TX path. A bank of
// runtime-writable seed registers holds the timeout lengths. The TX lane FSM
// raises TimerEn, selects a seed and a mode, and waits for Timeout.
//
// Ports
//   clk        in   1       rising-edge clock
//   RstN       in   1       asynchronous active-low reset
//   TimerEn    in   1       high = run, low = stop and clear
//   TimerSeed  in   SEED_W  seed index, sampled only at start
//   TimerMode  in   1       sampled only at start: 0 = one-shot sticky, 1 = periodic pulse
//   CfgWe      in   1       seed register write strobe
//   CfgIdx     in   SEED_W  seed register index to write
//   CfgData    in   CNT_W   seed value to write
//   Timeout    out  1       registered timeout indication
//   Busy       out  1       registered, high while counting
//   Elapsed    out  CNT_W   registered current count

// Seed register file. Writes to an index beyond the bank are dropped. A read
// of an index beyond the bank returns entry 0.
module tx_timer_seed_bank #(
  parameter int NUM_SEEDS = 4,
  parameter int CNT_W     = 16,
  parameter int SEED_W    = $clog2(NUM_SEEDS),
  parameter logic [NUM_SEEDS*CNT_W-1:0] DEF_SEEDS = {16'd99, 16'd49, 16'd29, 16'd14}
) (
  input  logic              clk,
  input  logic              RstN,
  input  logic              CfgWe,
  input  logic [SEED_W-1:0] CfgIdx,
  input  logic [CNT_W-1:0]  CfgData,
  input  logic [SEED_W-1:0] RdIdx,
  output logic [CNT_W-1:0]  RdData
);

  localparam logic [SEED_W:0] NUM_SEEDS_L = (SEED_W+1)'(NUM_SEEDS);

  logic [CNT_W-1:0]  seed_q [NUM_SEEDS];
  logic              wr_ok;
  logic              rd_ok;
  logic [SEED_W-1:0] rd_sel;

  assign wr_ok  = ({1'b0, CfgIdx} < NUM_SEEDS_L);
  assign rd_ok  = ({1'b0, RdIdx} < NUM_SEEDS_L);
  assign rd_sel = rd_ok ? RdIdx : '0;
  assign RdData = seed_q[rd_sel];

  always_ff @(posedge clk or negedge RstN) begin
    if (!RstN) begin
      for (int i = 0; i < NUM_SEEDS; i++) begin
        seed_q[i] <= DEF_SEEDS[i*CNT_W +: CNT_W];
      end
    end else if (CfgWe && wr_ok) begin
      seed_q[CfgIdx] <= CfgData;
    end
  end

endmodule

// State table
//   state       | meaning
//   ST_IDLE     | stopped, all outputs low, waiting for TimerEn
//   ST_RUN      | counting 1..Tlat, periodic runs wrap back to 1
//   ST_EXPIRED  | one-shot reached Tlat, Timeout held until TimerEn drops
module tx_timer_multi #(
  parameter int NUM_SEEDS = 4,
  parameter int CNT_W     = 16,
  parameter int SEED_W    = $clog2(NUM_SEEDS),
  parameter logic [NUM_SEEDS*CNT_W-1:0] DEF_SEEDS = {16'd99, 16'd49, 16'd29, 16'd14}
) (
  input  logic              clk,
  input  logic              RstN,
  input  logic              TimerEn,
  input  logic [SEED_W-1:0] TimerSeed,
  input  logic              TimerMode,
  input  logic              CfgWe,
  input  logic [SEED_W-1:0] CfgIdx,
  input  logic [CNT_W-1:0]  CfgData,
  output logic              Timeout,
  output logic              Busy,
  output logic [CNT_W-1:0]  Elapsed
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_EXPIRED = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state_q;
  logic [CNT_W-1:0] tlat_q;
  logic             mode_q;
  logic [CNT_W-1:0] cnt_q;
  logic             timeout_q;
  logic             busy_q;

  logic [CNT_W-1:0] seed_rd;
  logic [CNT_W-1:0] tlat_start;
  logic             start_tc;
  logic [CNT_W-1:0] cnt_next;
  logic             run_tc;

  tx_timer_seed_bank #(
    .NUM_SEEDS (NUM_SEEDS),
    .CNT_W     (CNT_W),
    .SEED_W    (SEED_W),
    .DEF_SEEDS (DEF_SEEDS)
  ) u_seed_bank (
    .clk     (clk),
    .RstN    (RstN),
    .CfgWe   (CfgWe),
    .CfgIdx  (CfgIdx),
    .CfgData (CfgData),
    .RdIdx   (TimerSeed),
    .RdData  (seed_rd)
  );

  // A zero seed is treated as 1 so the counter always has a terminal count.
  // The bank register is read before any same-edge write lands, so a start
  // coinciding with a write to its own seed uses the old value.
  assign tlat_start = (seed_rd == '0) ? ONE : seed_rd;
  assign start_tc   = (tlat_start == ONE);

  // The count never passes tlat_q, so cnt_q + 1 cannot wrap.
  assign cnt_next = (cnt_q == tlat_q) ? ONE : (cnt_q + ONE);
  assign run_tc   = (cnt_next == tlat_q);

  always_ff @(posedge clk or negedge RstN) begin
    if (!RstN) begin
      state_q   <= ST_IDLE;
      tlat_q    <= ONE;
      mode_q    <= 1'b0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
    end else if (!TimerEn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          tlat_q    <= tlat_start;
          mode_q    <= TimerMode;
          cnt_q     <= ONE;
          timeout_q <= start_tc;
          if (start_tc && !TimerMode) begin
            state_q <= ST_EXPIRED;
            busy_q  <= 1'b0;
          end else begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
          end
        end

        ST_RUN: begin
          cnt_q     <= cnt_next;
          timeout_q <= run_tc;
          if (!mode_q && run_tc) begin
            state_q <= ST_EXPIRED;
            busy_q  <= 1'b0;
          end
        end

        ST_EXPIRED: begin
          cnt_q     <= tlat_q;
          timeout_q <= 1'b1;
          busy_q    <= 1'b0;
        end

        default: begin
          state_q   <= ST_IDLE;
          cnt_q     <= '0;
          timeout_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign Timeout = timeout_q;
  assign Busy    = busy_q;
  assign Elapsed = cnt_q;

endmodule

// File: tb/tb_tx_timer_multi.sv
// Testbench for tx_timer_multi: directed scenarios plus a randomized phase,
// all checked every cycle against a reference model that derives the outputs
// from the number of edges since the run started.
module tb_tx_timer_multi;

  localparam int NS = 4;
  localparam int CW = 16;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          RstN = 1'b0;
  logic          TimerEn = 1'b0;
  logic [SW-1:0] TimerSeed = '0;
  logic          TimerMode = 1'b0;
  logic          CfgWe = 1'b0;
  logic [SW-1:0] CfgIdx = '0;
  logic [CW-1:0] CfgData = '0;
  logic          Timeout;
  logic          Busy;
  logic [CW-1:0] Elapsed;

  tx_timer_multi dut (
    .clk       (clk),
    .RstN      (RstN),
    .TimerEn   (TimerEn),
    .TimerSeed (TimerSeed),
    .TimerMode (TimerMode),
    .CfgWe     (CfgWe),
    .CfgIdx    (CfgIdx),
    .CfgData   (CfgData),
    .Timeout   (Timeout),
    .Busy      (Busy),
    .Elapsed   (Elapsed)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int m_seed [NS];
  bit m_run;
  int m_k;
  int m_tlat;
  bit m_mode;

  // observation helpers for directed scenarios
  int edge_no;
  int first_to;
  int n_high;
  int pulses[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_seed[0] = 14;
    m_seed[1] = 29;
    m_seed[2] = 49;
    m_seed[3] = 99;
    m_run = 1'b0;
    m_k = 0;
  endtask

  task automatic model_step();
    int idx;
    int sv;
    if (!RstN) return;
    if (!TimerEn) begin
      m_run = 1'b0;
    end else if (!m_run) begin
      idx    = (int'(TimerSeed) < NS) ? int'(TimerSeed) : 0;
      sv     = m_seed[idx];
      m_tlat = (sv == 0) ? 1 : sv;
      m_mode = TimerMode;
      m_run  = 1'b1;
      m_k    = 0;
    end else begin
      m_k++;
    end
    if (CfgWe && int'(CfgIdx) < NS) m_seed[CfgIdx] = int'(CfgData);
  endtask

  task automatic model_check();
    int n;
    int e_to;
    int e_busy;
    int e_el;
    if (!m_run) begin
      e_to = 0; e_busy = 0; e_el = 0;
    end else begin
      n = m_k + 1;
      if (m_mode) begin
        e_el   = ((n - 1) % m_tlat) + 1;
        e_to   = (n % m_tlat == 0) ? 1 : 0;
        e_busy = 1;
      end else begin
        e_el   = (n < m_tlat) ? n : m_tlat;
        e_to   = (n >= m_tlat) ? 1 : 0;
        e_busy = (n < m_tlat) ? 1 : 0;
      end
    end
    chk("timeout", 32'(Timeout), 32'(e_to));
    chk("busy", 32'(Busy), 32'(e_busy));
    chk("elapsed", 32'(Elapsed), 32'(e_el));
  endtask

  task automatic mark();
    edge_no  = 0;
    first_to = -1;
    n_high   = 0;
    pulses.delete();
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    model_check();
    if (Timeout === 1'b1) begin
      n_high++;
      pulses.push_back(edge_no);
      if (first_to < 0) first_to = edge_no;
    end
    edge_no++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic cfg_write(input int idx, input int val);
    CfgWe   = 1'b1;
    CfgIdx  = SW'(idx);
    CfgData = CW'(val);
    cycle();
    CfgWe   = 1'b0;
  endtask

  task automatic start(input int seed, input bit mode);
    TimerSeed = SW'(seed);
    TimerMode = mode;
    TimerEn   = 1'b1;
    mark();
  endtask

  task automatic stop();
    TimerEn = 1'b0;
    cycle();
  endtask

  initial begin
    model_reset();
    mark();
    #2;
    chk("rst_timeout", 32'(Timeout), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_elapsed", 32'(Elapsed), 32'd0);
    run(2);
    RstN = 1'b1;

    // one-shot default entry 0, drop enable at edge 20
    start(0, 1'b0);
    run(20);
    chk("t1_first_timeout", 32'(first_to), 32'd13);
    stop();
    chk("t1_stop_timeout", 32'(Timeout), 32'd0);
    chk("t1_stop_elapsed", 32'(Elapsed), 32'd0);

    // periodic entry 1
    start(1, 1'b1);
    run(90);
    chk("t2_npulses", 32'(pulses.size()), 32'd3);
    if (pulses.size() == 3) begin
      chk("t2_pulse0", 32'(pulses[0]), 32'd28);
      chk("t2_pulse1", 32'(pulses[1]), 32'd57);
      chk("t2_pulse2", 32'(pulses[2]), 32'd86);
    end
    stop();

    // idle write then start, and write coinciding with start
    cfg_write(2, 5);
    start(2, 1'b0);
    run(8);
    chk("t3_seed2_first", 32'(first_to), 32'd4);
    stop();
    start(0, 1'b0);
    CfgWe = 1'b1; CfgIdx = 2'd0; CfgData = 16'd3;
    cycle();
    CfgWe = 1'b0;
    run(16);
    chk("t3_old_seed_first", 32'(first_to), 32'd13);
    stop();
    start(0, 1'b0);
    run(5);
    chk("t3_new_seed_first", 32'(first_to), 32'd2);
    stop();

    // zero seed behaves as 1
    cfg_write(3, 0);
    start(3, 1'b0);
    run(3);
    chk("t4_oneshot_first", 32'(first_to), 32'd0);
    chk("t4_oneshot_held", 32'(n_high), 32'd3);
    stop();
    start(3, 1'b1);
    run(5);
    chk("t4_periodic_high", 32'(n_high), 32'd5);
    stop();

    // short drop of enable restarts the count
    cfg_write(0, 14);
    start(0, 1'b0);
    run(7);
    TimerEn = 1'b0;
    run(2);
    TimerEn = 1'b1;
    run(17);
    chk("t5_restart_first", 32'(first_to), 32'd22);
    stop();

    // reset mid-run restores defaults
    cfg_write(1, 7);
    start(1, 1'b0);
    run(10);
    RstN = 1'b0;
    #1;
    model_reset();
    chk("t6_rst_timeout", 32'(Timeout), 32'd0);
    chk("t6_rst_busy", 32'(Busy), 32'd0);
    chk("t6_rst_elapsed", 32'(Elapsed), 32'd0);
    cycle();
    RstN = 1'b1;
    mark();
    run(32);
    chk("t6_default_first", 32'(first_to), 32'd28);
    stop();

    // randomized phase
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) TimerEn = ~TimerEn;
      TimerSeed = SW'($urandom);
      TimerMode = 1'($urandom);
      CfgWe     = ($urandom_range(0, 7) == 0);
      CfgIdx    = SW'($urandom);
      CfgData   = ($urandom_range(0, 3) == 0) ? CW'($urandom_range(0, 2)) : CW'($urandom_range(3, 25));
      if (i == 700) begin
        RstN = 1'b0;
        #1;
        model_reset();
        model_check();
        cycle();
        RstN = 1'b1;
      end else begin
        cycle();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_timer_multi.md
# tx_timer_multi

Parametrised, multi-seed, programmable timeout generator for the C-PHY master TX path. It replaces the fixed two-value TX timer with a bank of runtime-writable seed registers and a selectable one-shot or periodic mode. It also adds busy and elapsed-count status outputs. It sits beside the TX lane FSM, which raises `TimerEn`, selects a seed and waits for `Timeout`.

## Interface
Parameters:
- `NUM_SEEDS`, 4: number of seed registers; minimum 2.
- `CNT_W`, 16: counter and seed width in bits.
- `SEED_W`, $clog2(NUM_SEEDS): seed index width; derived, do not override.
- `DEF_SEEDS`, {16'd99, 16'd49, 16'd29, 16'd14}: packed reset values. Entry i is bits [i*CNT_W +: CNT_W]. Entry 0 is LP-TX/Prepare (50 ns at 3.33 ns/clk); entry 1 is TA-Go (100 ns).

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `RstN`  in  1  asynchronous, active-low reset.
- `TimerEn`  in  1  level; high = run, low = stop and clear.
- `TimerSeed`  in  SEED_W  seed index, sampled only at start.
- `TimerMode`  in  1  sampled only at start; 0 = one-shot sticky, 1 = periodic pulse.
- `CfgWe`  in  1  seed register write strobe.
- `CfgIdx`  in  SEED_W  seed register index to write.
- `CfgData`  in  CNT_W  value to write.
- `Timeout`  out  1  registered timeout indication.
- `Busy`  out  1  registered; high while counting (RUN state).
- `Elapsed`  out  CNT_W  registered current count.

## Operation
- Seed bank: NUM_SEEDS registers of CNT_W bits, loaded from DEF_SEEDS on reset.
  - A write occurs at any edge with `CfgWe`=1, in any state.
  - A `CfgIdx` value of NUM_SEEDS or above is ignored.
- Internal latched values, captured at start:
  - Tlat = max(seed[TimerSeed], 1). A `TimerSeed` value of NUM_SEEDS or above selects entry 0.
  - Mlat = `TimerMode`.
- States: IDLE, RUN, EXPIRED.
- IDLE:
  - Outputs: c=0, `Timeout`=0, `Busy`=0.
  - On `TimerEn`=1: latch Tlat and Mlat, set c=1, and set `Timeout`=(Tlat==1).
  - Next state: EXPIRED if Tlat==1 and Mlat=0; otherwise RUN.
- RUN (while `TimerEn`=1):
  - Next count: cnext = (c==Tlat) ? 1 : c+1. Set c=cnext and `Timeout`=(cnext==Tlat).
  - If Mlat=0 and cnext==Tlat: go to EXPIRED.
- EXPIRED (one-shot only):
  - c holds at Tlat and `Timeout` holds at 1.
  - The block stays here until `TimerEn`=0.
- Any state, at any edge with `TimerEn`=0: go to IDLE with c=0 and `Timeout`=0.
- Outputs: `Busy` = (state==RUN); `Elapsed` = c.
- Arithmetic: c never exceeds Tlat, so there is no overflow or wrap beyond Tlat. Tlat=2^CNT_W-1 is legal.
- Mid-run changes:
  - A seed write, `TimerSeed` change or `TimerMode` change during RUN or EXPIRED does not affect the current run.
  - The new value applies at the next start.
- Simultaneous write and start at the same edge, to the same index: the start latches the old value, and the write still lands.

## Timing
- Edge numbering: edge 0 is the first edge at which `TimerEn` is sampled high in IDLE.
- One-shot: `Timeout` goes high after edge Tlat-1 and stays high until the edge that samples `TimerEn`=0. It clears after that edge.
- Periodic: `Timeout` is a 1-cycle pulse after edges Tlat-1, 2·Tlat-1, 3·Tlat-1, …
  - The period is Tlat cycles.
  - With Tlat=1, `Timeout` stays high continuously.
- Stop latency: one edge from `TimerEn` low to all outputs low.
- Restart: restarting after stop re-counts from 1. Dropping `TimerEn` for a single cycle fully restarts the count.
- Reset: asynchronous assert drives `Timeout`=0, `Busy`=0, `Elapsed`=0, state IDLE, and the seed bank to DEF_SEEDS. A reset mid-run aborts with no pulse.
- Reset release: the first edge after `RstN` rises may start the timer.

## Test plan
- Default entry 0, one-shot, `TimerEn` high from edge 0 -> `Timeout`=1 after edge 13 with `Elapsed`=14 and `Busy`=0 from then on. Drop `TimerEn` at edge 20 -> all outputs 0 after edge 20.
- Entry 1, periodic -> `Timeout` pulses after edges 28, 57 and 86 only. `Busy`=1 throughout; `Elapsed` goes 29 then 1.
- Write entry 2=5 (the block is idle when the write lands), then start seed 2 one-shot -> `Timeout` after edge 4. Write entry 0=3 at the same edge as a seed-0 start -> that run times out after edge 13, and the next run after edge 2.
- Write entry 3=0, start seed 3 one-shot -> `Timeout`=1 after edge 0. Same in periodic -> `Timeout` held high every cycle.
- Start entry 0, deassert `TimerEn` at edge 7, reassert at edge 9 -> `Timeout` after edge 22 (9+13), with no pulse before.
- Assert `RstN`=0 mid-run at edge 10 after writing entry 1=7 -> outputs 0 immediately. After release, a seed-1 one-shot times out 29 edges after start (entry 1 restored to default).
